// File: rtl/data_ram_arbiter.sv
// Round-robin two-port arbiter and access sequencer for the single-port data_ram.
// Each grant drives one ACCESS cycle (cs high) and one CAPTURE cycle, then a one-cycle ack.
module data_ram_arbiter #(
  parameter int ADDRESS_BUS_WIDTH = 16,
  parameter int DATA_BUS_WIDTH    = 16
) (
  input  logic                         clk,
  input  logic                         reset_n,
  input  logic                         req_a,
  input  logic                         rnw_a,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr_a,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata_a,
  input  logic                         req_b,
  input  logic                         rnw_b,
  input  logic [ADDRESS_BUS_WIDTH-1:0] addr_b,
  input  logic [DATA_BUS_WIDTH-1:0]    wdata_b,
  output logic                         ack_a,
  output logic [DATA_BUS_WIDTH-1:0]    rdata_a,
  output logic                         ack_b,
  output logic [DATA_BUS_WIDTH-1:0]    rdata_b,
  output logic                         busy,
  output logic [ADDRESS_BUS_WIDTH-1:0] ram_address,
  output logic [DATA_BUS_WIDTH-1:0]    ram_write_data,
  output logic                         ram_read_not_write,
  output logic                         ram_cs,
  input  logic [DATA_BUS_WIDTH-1:0]    ram_read_data
);

  typedef enum logic [1:0] {
    S_IDLE    = 2'd0,
    S_ACCESS  = 2'd1,
    S_CAPTURE = 2'd2
  } state_t;

  typedef enum logic {
    GRANT_A = 1'b0,
    GRANT_B = 1'b1
  } grant_t;

  state_t                       r_state;
  state_t                       w_next_state;
  grant_t                       r_grant;
  grant_t                       r_last_grant;
  grant_t                       w_grant_sel;
  logic                         w_do_grant;
  logic                         w_elig_a;
  logic                         w_elig_b;

  logic [ADDRESS_BUS_WIDTH-1:0] r_ram_address;
  logic [DATA_BUS_WIDTH-1:0]    r_ram_write_data;
  logic                         r_ram_rnw;
  logic                         r_ram_cs;
  logic                         r_ack_a;
  logic                         r_ack_b;
  logic [DATA_BUS_WIDTH-1:0]    r_rdata_a;
  logic [DATA_BUS_WIDTH-1:0]    r_rdata_b;

  // A requester is masked during its own ack cycle so a still-held req is not regranted.
  assign w_elig_a = req_a & ~r_ack_a;
  assign w_elig_b = req_b & ~r_ack_b;

  always_comb begin
    // NOTE: every always_comb output gets a default first so no path can infer a latch.
    w_next_state = r_state;
    w_grant_sel  = GRANT_A;
    w_do_grant   = 1'b0;
    unique case (r_state)
      S_IDLE: begin
        if (w_elig_a && w_elig_b) begin
          w_grant_sel  = (r_last_grant == GRANT_A) ? GRANT_B : GRANT_A;
          w_do_grant   = 1'b1;
        end else if (w_elig_a) begin
          w_grant_sel  = GRANT_A;
          w_do_grant   = 1'b1;
        end else if (w_elig_b) begin
          w_grant_sel  = GRANT_B;
          w_do_grant   = 1'b1;
        end
        if (w_do_grant) begin
          w_next_state = S_ACCESS;
        end
      end
      S_ACCESS:  w_next_state = S_CAPTURE;
      S_CAPTURE: w_next_state = S_IDLE;
      default:   w_next_state = S_IDLE;
    endcase
  end

  // NOTE: state is updated with non-blocking assignments so every flop samples pre-edge values.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_state <= S_IDLE;
    end else begin
      r_state <= w_next_state;
    end
  end

  // RAM-side fields are captured at grant and held until the next grant.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      r_grant          <= GRANT_A;
      r_last_grant     <= GRANT_B;
      r_ram_address    <= '0;
      r_ram_write_data <= '0;
      r_ram_rnw        <= 1'b1;
      r_ram_cs         <= 1'b0;
    end else begin
      r_ram_cs <= w_do_grant;
      if (w_do_grant) begin
        r_grant      <= w_grant_sel;
        r_last_grant <= w_grant_sel;
        if (w_grant_sel == GRANT_B) begin
          r_ram_address    <= addr_b;
          r_ram_write_data <= wdata_b;
          r_ram_rnw        <= rnw_b;
        end else begin
          r_ram_address    <= addr_a;
          r_ram_write_data <= wdata_a;
          r_ram_rnw        <= rnw_a;
        end
      end
    end
  end

  // Read data is only valid from the RAM during CAPTURE; writes leave rdata untouched.
  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      // NOTE: the read-data holding registers are ordinary flops and are reset explicitly.
      r_ack_a   <= 1'b0;
      r_ack_b   <= 1'b0;
      r_rdata_a <= '0;
      r_rdata_b <= '0;
    end else begin
      r_ack_a <= 1'b0;
      r_ack_b <= 1'b0;
      if (r_state == S_CAPTURE) begin
        if (r_grant == GRANT_B) begin
          r_ack_b <= 1'b1;
          if (r_ram_rnw) begin
            r_rdata_b <= ram_read_data;
          end
        end else begin
          r_ack_a <= 1'b1;
          if (r_ram_rnw) begin
            r_rdata_a <= ram_read_data;
          end
        end
      end
    end
  end

  assign ack_a              = r_ack_a;
  assign ack_b              = r_ack_b;
  assign rdata_a            = r_rdata_a;
  assign rdata_b            = r_rdata_b;
  assign busy               = (r_state != S_IDLE);
  assign ram_address        = r_ram_address;
  assign ram_write_data     = r_ram_write_data;
  assign ram_read_not_write = r_ram_rnw;
  assign ram_cs             = r_ram_cs;

endmodule

// File: tb/tb_data_ram_arbiter.sv
// Self-checking bench for data_ram_arbiter with a byte-addressed, one-cycle-latency RAM model.
// Table-driven single accesses plus hand-written contention, alternation and reset sequences.
module tb_data_ram_arbiter;

  logic        clk = 1'b0;
  logic        reset_n = 1'b0;
  logic        req_a = 1'b0, rnw_a = 1'b1, req_b = 1'b0, rnw_b = 1'b1;
  logic [15:0] addr_a = '0, wdata_a = '0, addr_b = '0, wdata_b = '0;
  logic        ack_a, ack_b, busy, ram_read_not_write, ram_cs;
  logic [15:0] rdata_a, rdata_b, ram_address, ram_write_data, ram_read_data;

  int n_checks = 0;
  int n_errors = 0;
  int ack_viol = 0;
  logic prev_ack_a = 1'b0, prev_ack_b = 1'b0;

  always #5 clk = ~clk;

  data_ram_arbiter #(.ADDRESS_BUS_WIDTH(16), .DATA_BUS_WIDTH(16)) dut (
    .clk(clk), .reset_n(reset_n),
    .req_a(req_a), .rnw_a(rnw_a), .addr_a(addr_a), .wdata_a(wdata_a),
    .req_b(req_b), .rnw_b(rnw_b), .addr_b(addr_b), .wdata_b(wdata_b),
    .ack_a(ack_a), .rdata_a(rdata_a), .ack_b(ack_b), .rdata_b(rdata_b),
    .busy(busy), .ram_address(ram_address), .ram_write_data(ram_write_data),
    .ram_read_not_write(ram_read_not_write), .ram_cs(ram_cs),
    .ram_read_data(ram_read_data)
  );

  // RAM model: little-endian word at address/address+1, read data valid only the cycle after cs.
  logic [7:0]  mem [0:65535];
  logic [15:0] ram_rd_q = 16'hA5A5;
  initial for (int i = 0; i < 65536; i++) mem[i] = 8'h00;
  always @(posedge clk) begin
    if (ram_cs) begin
      if (ram_read_not_write) begin
        ram_rd_q <= {mem[ram_address + 16'd1], mem[ram_address]};
      end else begin
        mem[ram_address]         <= ram_write_data[7:0];
        mem[ram_address + 16'd1] <= ram_write_data[15:8];
      end
    end else begin
      ram_rd_q <= 16'hA5A5;
    end
  end
  assign ram_read_data = ram_rd_q;

  // Acks must never overlap and never last two cycles.
  always @(negedge clk) begin
    if (reset_n) begin
      if (ack_a && ack_b) ack_viol <= ack_viol + 1;
      if ((ack_a && prev_ack_a) || (ack_b && prev_ack_b)) ack_viol <= ack_viol + 1;
    end
    prev_ack_a <= ack_a;
    prev_ack_b <= ack_b;
  end

  task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
    n_checks++;
    if (got !== exp) begin
      n_errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
    end
  endtask

  task automatic do_access(input logic pb, input logic rnw, input logic [15:0] addr,
                           input logic [15:0] wdata, output int lat, output int cs_cnt);
    @(negedge clk);
    if (pb) begin
      req_b = 1'b1; rnw_b = rnw; addr_b = addr; wdata_b = wdata;
    end else begin
      req_a = 1'b1; rnw_a = rnw; addr_a = addr; wdata_a = wdata;
    end
    lat = 0;
    cs_cnt = 0;
    for (int c = 1; c <= 20; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ram_cs) cs_cnt++;
      if (pb ? ack_b : ack_a) begin
        lat = c;
        break;
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
  endtask

  typedef struct {
    logic        pb;
    logic        rnw;
    logic [15:0] addr;
    logic [15:0] wdata;
    logic [15:0] exp_a;
    logic [15:0] exp_b;
  } vec_t;

  vec_t vecs [8];

  initial begin
    int lat, cs_cnt, t_a, t_b, n_acks;
    int ack_cyc [6];
    logic ack_who [6];

    vecs[0] = '{1'b0, 1'b0, 16'd6,  16'hBEEF, 16'h0000, 16'h0000};
    vecs[1] = '{1'b0, 1'b1, 16'd6,  16'h0000, 16'hBEEF, 16'h0000};
    vecs[2] = '{1'b1, 1'b0, 16'd9,  16'h1234, 16'hBEEF, 16'h0000};
    vecs[3] = '{1'b1, 1'b1, 16'd9,  16'h0000, 16'hBEEF, 16'h1234};
    vecs[4] = '{1'b0, 1'b0, 16'd20, 16'h5555, 16'hBEEF, 16'h1234};
    vecs[5] = '{1'b0, 1'b1, 16'd7,  16'h0000, 16'h00BE, 16'h1234};
    vecs[6] = '{1'b1, 1'b1, 16'd20, 16'h0000, 16'h00BE, 16'h5555};
    vecs[7] = '{1'b0, 1'b1, 16'd21, 16'h0000, 16'h0055, 16'h5555};

    // Reset values.
    repeat (2) @(negedge clk);
    check("rst_ram_cs", ram_cs, 0);
    check("rst_ram_rnw", ram_read_not_write, 1);
    check("rst_ram_address", ram_address, 0);
    check("rst_ram_wdata", ram_write_data, 0);
    check("rst_busy", busy, 0);
    check("rst_acks", {ack_a, ack_b}, 0);
    check("rst_rdata", {rdata_a, rdata_b}, 0);
    reset_n = 1'b1;

    for (int i = 0; i < 8; i++) begin
      do_access(vecs[i].pb, vecs[i].rnw, vecs[i].addr, vecs[i].wdata, lat, cs_cnt);
      check($sformatf("v%0d_latency", i), lat, 3);
      check($sformatf("v%0d_cs_cycles", i), cs_cnt, 1);
      check($sformatf("v%0d_ram_address", i), ram_address, vecs[i].addr);
      check($sformatf("v%0d_ram_rnw", i), ram_read_not_write, vecs[i].rnw);
      check($sformatf("v%0d_rdata_a", i), rdata_a, vecs[i].exp_a);
      check($sformatf("v%0d_rdata_b", i), rdata_b, vecs[i].exp_b);
    end

    // Simultaneous requests from reset: A first, B granted in A's ack cycle.
    @(negedge clk);
    reset_n = 1'b0;
    req_a = 1'b1; rnw_a = 1'b1; addr_a = 16'd6;
    req_b = 1'b1; rnw_b = 1'b1; addr_b = 16'd9;
    @(negedge clk);
    reset_n = 1'b1;
    t_a = 0;
    t_b = 0;
    for (int c = 1; c <= 20 && (t_a == 0 || t_b == 0); c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_a) begin t_a = c; req_a = 1'b0; end
      if (ack_b) begin t_b = c; req_b = 1'b0; end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check("contend_ack_a_cycle", t_a, 3);
    check("contend_ack_b_cycle", t_b, 6);
    check("contend_rdata_a", rdata_a, 16'hBEEF);
    check("contend_rdata_b", rdata_b, 16'h1234);

    // Both held high: grants must alternate A, B, A, B, A, B every 3 cycles.
    @(negedge clk);
    req_a = 1'b1; rnw_a = 1'b1; addr_a = 16'd20;
    req_b = 1'b1; rnw_b = 1'b1; addr_b = 16'd6;
    n_acks = 0;
    for (int c = 1; c <= 40 && n_acks < 6; c++) begin
      @(posedge clk);
      @(negedge clk);
      if (ack_a || ack_b) begin
        ack_cyc[n_acks] = c;
        ack_who[n_acks] = ack_b;
        n_acks++;
        if (n_acks == 6) begin req_a = 1'b0; req_b = 1'b0; end
      end
    end
    req_a = 1'b0;
    req_b = 1'b0;
    check("alt_ack_count", n_acks, 6);
    for (int k = 0; k < n_acks; k++) begin
      check($sformatf("alt%0d_who", k), ack_who[k], k % 2);
      check($sformatf("alt%0d_cycle", k), ack_cyc[k], 3 * (k + 1));
    end
    check("alt_rdata_a", rdata_a, 16'h5555);
    check("alt_rdata_b", rdata_b, 16'hBEEF);

    // Reset during ACCESS of an A read: everything returns to reset values, no ack.
    @(negedge clk);
    req_a = 1'b1; rnw_a = 1'b1; addr_a = 16'd9;
    @(posedge clk);
    @(negedge clk);
    check("midrst_in_access", ram_cs, 1);
    reset_n = 1'b0;
    #1;
    check("midrst_ram_cs", ram_cs, 0);
    check("midrst_busy", busy, 0);
    check("midrst_ram_rnw", ram_read_not_write, 1);
    check("midrst_ram_addr_wdata", {ram_address, ram_write_data}, 0);
    check("midrst_rdata", {rdata_a, rdata_b}, 0);
    req_a = 1'b0;
    t_a = 0;
    repeat (2) begin
      @(negedge clk);
      if (ack_a) t_a++;
    end
    reset_n = 1'b1;
    repeat (4) begin
      @(negedge clk);
      if (ack_a) t_a++;
    end
    check("midrst_no_ack", t_a, 0);

    do_access(1'b0, 1'b1, 16'd6, 16'h0000, lat, cs_cnt);
    check("post_rst_latency", lat, 3);
    check("post_rst_rdata_a", rdata_a, 16'hBEEF);

    // A write after a read keeps the read value.
    do_access(1'b0, 1'b0, 16'd30, 16'h0F0F, lat, cs_cnt);
    check("wr_after_rd_latency", lat, 3);
    check("wr_after_rd_rdata_a", rdata_a, 16'hBEEF);
    check("wr_after_rd_mem", {mem[31], mem[30]}, 16'h0F0F);

    repeat (2) @(negedge clk);
    check("ack_protocol", ack_viol, 0);

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

endmodule
